ipsmacge_lbout: RTL
===================

# ipsmacge_lbout

Loopback-out block for the GE MAC transmit side. In loopback-out mode it retransmits frames received on the RX byte stream onto the TX line interface, replacing the local MAC transmit stream. Frames are buffered in an internal synchronous FIFO and re-paced to the TX valid strobe. The RX stream is already retimed onto txclk, so the whole block runs on one clock. It sits between the MAC transmit engine and the line-side TX interface, as the counterpart of the loopback-in path.

## Interface
- LBOUT_AW, 4, FIFO address width; depth is 2^LBOUT_AW entries of 10 bits {er, dv, dat}.
- txclk  in  1  block clock; all logic is rising-edge.
- txrst  in  1  reset, synchronous, active-high.
- rx_idat/rx_idv/rx_ier/rx_ival  in  8/1/1/1  received stream (txclk domain); rx_ival is the byte strobe.
- tx_idat/tx_ien/tx_ier/tx_ival  in  8/1/1/1  local MAC transmit stream; tx_ival is the byte strobe.
- tx_odat/tx_oen/tx_oer/tx_oval  out  8/1/1/1  line-side transmit stream, registered.
- lbout_fifowrerr  out  1  one-cycle pulse: write attempted while FIFO full.
- lbout_fiforderr  out  1  one-cycle pulse: underrun inside a looped frame.
- uplbout  in  1  loopback-out request (static config).
- upfifofsh  in  1  FIFO flush request (level).
- uplbffnum  in  4  start threshold: entries needed before a frame starts; value 0 is treated as 1.

## Operation
- lb_en is the effective mode. It loads uplbout only on a cycle with:
  - rx_ival & !rx_idv,
  - tx_ival & !tx_ien,
  - state NORM or LWAIT.
- Mode changes therefore never cut a frame on either stream.
- FIFO write: wr = lb_en & rx_ival & (rx_idv | rx_idv_d), where rx_idv_d is rx_idv captured on the previous rx_ival cycle. Each frame is stored with one trailing end-marker entry (dv=0).
- Write while full: the entry is dropped and lbout_fifowrerr pulses.
- The FIFO head is read combinationally. rd advances the read pointer.
- len is LBOUT_AW+1 bits wide.
  - Full when len == 2^LBOUT_AW.
  - Simultaneous wr & rd leaves len unchanged.
  - Pointers wrap modulo depth.
- Flush: pointers and len go to 0 when !lb_en or upfifofsh. Flush overrides a simultaneous wr/rd.
- States:
  - NORM (lb_en=0): pass-through. tx_o* <= tx_i*, and tx_oval <= tx_ival.
  - LWAIT: outputs idle (odat=0, oen=0, oer=0) on each tx_ival cycle. Go to LSEND when len >= max(uplbffnum,1) and tx_ival.
  - LSEND: on each tx_ival cycle, rd=1 and the head is output with oen=dv, oer=er.
    - If the head has dv=0 (end marker), it is output as idle, then go to LWAIT (or LGAP when the macro is defined).
    - If the FIFO is empty: output oen=1, oer=1, odat=0x00; pulse lbout_fiforderr; no read; stay in LSEND.
  - LGAP (macro only): idle for 12 tx_ival cycles, then go to LWAIT.
- When lb_en falls (only possible in LWAIT), go to NORM.
- Local MAC tx_i* is discarded while lb_en=1.
- On cycles with !tx_ival, no read, no state change, and tx_oval <= 0.

## Timing
- Reset values: tx_odat=0, tx_oen=0, tx_oer=0, tx_oval=0, lbout_fifowrerr=0, lbout_fiforderr=0, lb_en=0, state NORM, len=0, pointers=0, rx_idv_d=0.
- Pass-through latency: 1 cycle.
- Loop latency: an entry written on cycle t is readable at t+1 and appears on tx_o* at the next tx_ival cycle plus 1 register.
- Both error pulses last exactly 1 cycle, coincident with the offending cycle + 1.
- Reset mid-frame: everything returns to reset values on the next edge; a partial FIFO frame is lost.

## Configuration
- IPSMACGE_LBOUT_MINIPG_EN defined: the LGAP state exists and looped frames are separated by at least 13 idle tx_ival cycles (end marker + 12).
- Not defined: LSEND goes directly to LWAIT. The minimum gap is the end marker plus LWAIT entry, i.e. 2 idle cycles when data is already queued.

## Test plan
- uplbout=0, tx_ival=1 continuously, 64-byte frame on tx_i* -> identical bytes on tx_o* 1 cycle later; FIFO len stays 0.
- uplbout=1 with both streams idle, uplbffnum=4, 20-byte rx frame, tx_ival=1 always -> tx_oen rises after the 4th entry is written; 20 bytes out in order, then oen=0.
- uplbout raised while a tx frame is in progress -> the tx frame completes untruncated; the looped frame starts only after tx_ien=0.
- tx_ival toggling 1/0, rx_ival=1, LBOUT_AW=4, 40-byte rx frame -> lbout_fifowrerr pulses once per dropped byte once len=16; no fiforderr.
- rx_ival at 1/3 duty, uplbffnum=1, long frame -> lbout_fiforderr pulses; tx_oen=1, tx_oer=1, odat=0x00 on underrun cycles.
- Macro defined, two back-to-back 10-byte rx frames -> exactly 13 idle tx_ival cycles between them on tx_o*; macro undefined -> 2.

Source files
------------

// File: rtl/ipsmacge_lbout.sv
// GE MAC transmit-side loopback-out: buffers the RX byte stream in a small FIFO and replays it on the TX line.
// Optional feature macro: IPSMACGE_LBOUT_MINIPG_EN adds a 12-cycle gap state between looped frames.
module ipsmacge_lbout #(
    parameter int LBOUT_AW = 4
) (
    input  logic       txclk,
    input  logic       txrst,
    input  logic [7:0] rx_idat,
    input  logic       rx_idv,
    input  logic       rx_ier,
    input  logic       rx_ival,
    input  logic [7:0] tx_idat,
    input  logic       tx_ien,
    input  logic       tx_ier,
    input  logic       tx_ival,
    output logic [7:0] tx_odat,
    output logic       tx_oen,
    output logic       tx_oer,
    output logic       tx_oval,
    output logic       lbout_fifowrerr,
    output logic       lbout_fiforderr,
    input  logic       uplbout,
    input  logic       upfifofsh,
    input  logic [3:0] uplbffnum
);

    localparam int DEPTH = 1 << LBOUT_AW;
    localparam logic [LBOUT_AW:0] FULL_LEN = (LBOUT_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        NORM  = 2'd0,
        LWAIT = 2'd1,
        LSEND = 2'd2,
        LGAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                lb_en_q, lb_en_d;
    logic                rx_idv_d_q;
    logic [9:0]          mem_q [DEPTH];
    logic [LBOUT_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LBOUT_AW:0]   len_q, len_d;
    logic [7:0]          tx_odat_q, tx_odat_d;
    logic                tx_oen_q, tx_oen_d, tx_oer_q, tx_oer_d, tx_oval_q;
    logic                wrerr_q, rderr_q, rderr_d;
`ifdef IPSMACGE_LBOUT_MINIPG_EN
    logic [3:0]          gap_q, gap_d;
`endif

    logic       wr_s, full_s, wr_ok_s, flush_s, rd_s, mode_ok_s, len_ge_thr_s;
    logic [9:0] head_s;
    logic [4:0] thr_s;

    assign wr_s         = lb_en_q & rx_ival & (rx_idv | rx_idv_d_q);
    assign full_s       = (len_q == FULL_LEN);
    assign wr_ok_s      = wr_s & ~full_s;
    assign flush_s      = ~lb_en_q | upfifofsh;
    assign head_s       = mem_q[rptr_q];
    assign thr_s        = (uplbffnum == 4'd0) ? 5'd1 : {1'b0, uplbffnum};
    assign len_ge_thr_s = (32'(len_q) >= 32'(thr_s));
    // Mode may only change between frames on both streams and outside a replay.
    assign mode_ok_s    = rx_ival & ~rx_idv & tx_ival & ~tx_ien &
                          ((state_q == NORM) | (state_q == LWAIT));

    // FIFO storage; entries are {er, dv, dat}
    always_ff @(posedge txclk) begin
        if (!txrst && !flush_s && wr_ok_s) begin
            mem_q[wptr_q] <= {rx_ier, rx_idv, rx_idat};
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        len_d  = len_q;
        if (flush_s) begin
            wptr_d = '0;
            rptr_d = '0;
            len_d  = '0;
        end else begin
            if (wr_ok_s) begin
                wptr_d = wptr_q + LBOUT_AW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_s) begin
                rptr_d = rptr_q + LBOUT_AW'(1);
            end else begin
                rptr_d = rptr_q;
            end
            case ({wr_ok_s, rd_s})
                2'b10:   len_d = len_q + (LBOUT_AW + 1)'(1);
                2'b01:   len_d = len_q - (LBOUT_AW + 1)'(1);
                default: len_d = len_q;
            endcase
        end
    end

    // Mode/state next-state and line-side output selection
    always_comb begin
        state_d   = state_q;
        lb_en_d   = lb_en_q;
        tx_odat_d = tx_odat_q;
        tx_oen_d  = tx_oen_q;
        tx_oer_d  = tx_oer_q;
        rd_s      = 1'b0;
        rderr_d   = 1'b0;
`ifdef IPSMACGE_LBOUT_MINIPG_EN
        gap_d     = gap_q;
`endif
        if (mode_ok_s) begin
            lb_en_d = uplbout;
        end else begin
            lb_en_d = lb_en_q;
        end
        case (state_q)
            NORM: begin
                tx_odat_d = tx_idat;
                tx_oen_d  = tx_ien;
                tx_oer_d  = tx_ier;
                if (mode_ok_s && uplbout) begin
                    state_d = LWAIT;
                end else begin
                    state_d = NORM;
                end
            end
            LWAIT: begin
                if (tx_ival) begin
                    tx_odat_d = 8'h00;
                    tx_oen_d  = 1'b0;
                    tx_oer_d  = 1'b0;
                    if (mode_ok_s && !uplbout) begin
                        state_d = NORM;
                    end else if (len_ge_thr_s) begin
                        state_d = LSEND;
                    end else begin
                        state_d = LWAIT;
                    end
                end else begin
                    state_d = LWAIT;
                end
            end
            LSEND: begin
                if (!tx_ival) begin
                    state_d = LSEND;
                end else if (len_q == '0) begin
                    // Underrun inside a frame: signal a line error rather than stall the line.
                    tx_odat_d = 8'h00;
                    tx_oen_d  = 1'b1;
                    tx_oer_d  = 1'b1;
                    rderr_d   = 1'b1;
                end else begin
                    rd_s = 1'b1;
                    if (head_s[8]) begin
                        tx_odat_d = head_s[7:0];
                        tx_oen_d  = 1'b1;
                        tx_oer_d  = head_s[9];
                    end else begin
                        tx_odat_d = 8'h00;
                        tx_oen_d  = 1'b0;
                        tx_oer_d  = 1'b0;
`ifdef IPSMACGE_LBOUT_MINIPG_EN
                        gap_d     = 4'd0;
                        state_d   = LGAP;
`else
                        state_d   = LWAIT;
`endif
                    end
                end
            end
`ifdef IPSMACGE_LBOUT_MINIPG_EN
            LGAP: begin
                if (tx_ival) begin
                    tx_odat_d = 8'h00;
                    tx_oen_d  = 1'b0;
                    tx_oer_d  = 1'b0;
                    // The last gap cycle doubles as the wait check so the gap is exactly 13 when data is queued.
                    if (gap_q == 4'd11) begin
                        if (len_ge_thr_s) begin
                            state_d = LSEND;
                        end else begin
                            state_d = LWAIT;
                        end
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end else begin
                    state_d = LGAP;
                end
            end
`endif
            default: begin
                state_d = NORM;
                lb_en_d = 1'b0;
            end
        endcase
    end

    // Registered state, FIFO control and outputs
    always_ff @(posedge txclk) begin
        if (txrst) begin
            state_q    <= NORM;
            lb_en_q    <= 1'b0;
            rx_idv_d_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            len_q      <= '0;
            tx_odat_q  <= 8'h00;
            tx_oen_q   <= 1'b0;
            tx_oer_q   <= 1'b0;
            tx_oval_q  <= 1'b0;
            wrerr_q    <= 1'b0;
            rderr_q    <= 1'b0;
`ifdef IPSMACGE_LBOUT_MINIPG_EN
            gap_q      <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            lb_en_q    <= lb_en_d;
            rx_idv_d_q <= rx_ival ? rx_idv : rx_idv_d_q;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            len_q      <= len_d;
            tx_odat_q  <= tx_odat_d;
            tx_oen_q   <= tx_oen_d;
            tx_oer_q   <= tx_oer_d;
            tx_oval_q  <= tx_ival;
            wrerr_q    <= wr_s & full_s;
            rderr_q    <= rderr_d;
`ifdef IPSMACGE_LBOUT_MINIPG_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign tx_odat         = tx_odat_q;
    assign tx_oen          = tx_oen_q;
    assign tx_oer          = tx_oer_q;
    assign tx_oval         = tx_oval_q;
    assign lbout_fifowrerr = wrerr_q;
    assign lbout_fiforderr = rderr_q;

endmodule
